pipe_stage_skid: RTL and testbench

//  Parametrised successor to the fixed ID/EX-style stage registers. Drops between any two

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 38 +++
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Includes the skid FSM state encoding and the control value that means "no operation".
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } skid_state_t;

   // All-zero control is a bubble in every stage; widen or narrow with a cast at the use site.
   localparam int unsigned CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// Used for the stall and bubble performance counters.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Hold at all-ones instead of wrapping, so long stalls never read back as small numbers.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and valid/ready handshaking.
// Also provides a synchronous flush-to-bubble and saturating stall/bubble counters.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W              = 64,
   parameter int CTRL_W              = 16,
   parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
   parameter int CNT_W               = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              cnt_clear,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

   skid_state_t       state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              push;
   logic              pop;

   assign push = in_valid & in_ready_q;
   assign pop  = (state_q != ST_EMPTY) & out_ready;

   // Any slot that is not holding a live entry keeps ctrl at NOP, so out_ctrl is 0 when idle.
   // in_ready is precomputed from the next state, so it comes straight from a flop.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         main_ctrl_d = NOP;
         skid_ctrl_d = NOP;
         if (CLEAR_DATA_ON_FLUSH) begin
            main_data_d = '0;
            skid_data_d = '0;
         end
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d     = ST_ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ST_ONE: begin
               if (push && !pop) begin
                  state_d     = ST_TWO;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (push && pop) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (pop) begin
                  state_d     = ST_EMPTY;
                  main_ctrl_d = NOP;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  skid_ctrl_d = NOP;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_ctrl_d = NOP;
               skid_ctrl_d = NOP;
            end
         endcase
      end
      in_ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= NOP;
         skid_data_q <= '0;
         skid_ctrl_q <= NOP;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clear),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clear),
      .inc   (~out_valid & out_ready),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid using a FIFO scoreboard and saturating counter models.
// Two instances are driven identically; they differ in CNT_W and in CLEAR_DATA_ON_FLUSH.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic [15:0] in_ctrl;
   logic        out_ready;
   logic        cnt_clear;

   logic        aInReady, aOutValid;
   logic [63:0] aOutData;
   logic [15:0] aOutCtrl;
   logic [3:0]  aStall, aBubble;

   logic        bInReady, bOutValid;
   logic [63:0] bOutData;
   logic [15:0] bOutCtrl;
   logic [15:0] bStall, bBubble;

   int          checks = 0;
   int          errors = 0;
   logic [79:0] sbQ[$];
   int          popCount = 0;
   int          popBase;
   bit          saw9 = 0;
   int          stallExp = 0;
   int          bubbleExp = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(64), .CTRL_W(16), .CLEAR_DATA_ON_FLUSH(1'b0), .CNT_W(4)) dutA (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(aInReady), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(aOutValid), .out_ready(out_ready), .out_data(aOutData), .out_ctrl(aOutCtrl),
      .cnt_clear(cnt_clear), .stall_cnt(aStall), .bubble_cnt(aBubble)
   );

   pipe_stage_skid #(.DATA_W(64), .CTRL_W(16), .CLEAR_DATA_ON_FLUSH(1'b1), .CNT_W(16)) dutB (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(bInReady), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(bOutValid), .out_ready(out_ready), .out_data(bOutData), .out_ctrl(bOutCtrl),
      .cnt_clear(cnt_clear), .stall_cnt(bStall), .bubble_cnt(bBubble)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, then score the handshake at the falling edge and the counters after the rise.
   task automatic applyStimulus(input bit iv, input logic [15:0] ic, input logic [63:0] id,
                                input bit ordy, input bit fl, input bit clr);
      logic [79:0] head;
      bit          expValid;
      bit          canPush;
      in_valid  = iv;
      in_ctrl   = ic;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      cnt_clear = clr;
      @(negedge clk);
      expValid = (sbQ.size() != 0);
      canPush  = (sbQ.size() < 2);
      checkOutput("out_valid", 64'(aOutValid), 64'(expValid));
      checkOutput("in_ready", 64'(aInReady), 64'(canPush));
      if (!expValid) checkOutput("idle_ctrl", 64'(aOutCtrl), 64'(0));
      if (aOutValid && aOutCtrl == 16'd9) saw9 = 1'b1;
      if (expValid && ordy) begin
         head = sbQ.pop_front();
         checkOutput("out_ctrl", 64'(aOutCtrl), 64'(head[79:64]));
         checkOutput("out_data", aOutData, head[63:0]);
         popCount++;
      end
      if (fl) sbQ.delete();
      else if (iv && canPush) sbQ.push_back({ic, id});
      if (clr) begin
         stallExp  = 0;
         bubbleExp = 0;
      end else begin
         if (expValid && !ordy && stallExp < 15) stallExp++;
         if (!expValid && ordy && bubbleExp < 15) bubbleExp++;
      end
      @(posedge clk);
      #1;
      checkOutput("stall_cnt", 64'(aStall), 64'(stallExp));
      checkOutput("bubble_cnt", 64'(aBubble), 64'(bubbleExp));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      out_ready = 1'b0; cnt_clear = 1'b0;
      #3;
      checkOutput("rst_valid", 64'(aOutValid), 64'(0));
      checkOutput("rst_ready", 64'(aInReady), 64'(1));
      checkOutput("rst_ctrl", 64'(aOutCtrl), 64'(0));
      checkOutput("rst_data", aOutData, 64'(0));
      checkOutput("rst_cnt", 64'({aStall, aBubble}), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fill to TWO, then reset asynchronously mid-cycle.
      applyStimulus(1, 16'h11, 64'h11, 0, 0, 0);
      applyStimulus(1, 16'h12, 64'h12, 0, 0, 0);
      checkOutput("t1_two_ready", 64'(aInReady), 64'(0));
      reset = 1'b1;
      #1;
      checkOutput("t1_rst_valid", 64'(aOutValid), 64'(0));
      checkOutput("t1_rst_ctrl", 64'(aOutCtrl), 64'(0));
      checkOutput("t1_rst_ready", 64'(aInReady), 64'(1));
      checkOutput("t1_rst_stall", 64'(aStall), 64'(0));
      checkOutput("t1_rst_bubble", 64'(aBubble), 64'(0));
      sbQ.delete();
      stallExp  = 0;
      bubbleExp = 0;
      #1;
      reset = 1'b0;

      // Full-rate streaming.
      popBase = popCount;
      for (int i = 1; i <= 5; i++) applyStimulus(1, 16'(i), 64'h100 + 64'(i), 1, 0, 0);
      applyStimulus(0, 16'h0, 64'h0, 1, 0, 0);
      checkOutput("t2_count", 64'(popCount - popBase), 64'(5));

      // Backpressure: stall with entry 3 held off, then drain in order.
      applyStimulus(0, 16'h0, 64'h0, 0, 0, 1);
      popBase = popCount;
      applyStimulus(1, 16'd1, 64'h201, 0, 0, 0);
      applyStimulus(1, 16'd2, 64'h202, 0, 0, 0);
      checkOutput("t3_full", 64'(aInReady), 64'(0));
      applyStimulus(1, 16'd3, 64'h203, 0, 0, 0);
      applyStimulus(1, 16'd3, 64'h203, 0, 0, 0);
      checkOutput("t3_stall3", 64'(aStall), 64'(3));
      applyStimulus(1, 16'd3, 64'h203, 1, 0, 0);
      applyStimulus(1, 16'd3, 64'h203, 1, 0, 0);
      for (int n = 0; n < 8 && sbQ.size() != 0; n++) applyStimulus(0, 16'h0, 64'h0, 1, 0, 0);
      checkOutput("t3_drained", 64'(sbQ.size()), 64'(0));
      checkOutput("t3_count", 64'(popCount - popBase), 64'(3));

      // Flush while full with a new entry presented.
      saw9 = 1'b0;
      applyStimulus(1, 16'd7, 64'h307, 0, 0, 0);
      applyStimulus(1, 16'd8, 64'h308, 0, 0, 0);
      applyStimulus(1, 16'd9, 64'h309, 0, 1, 0);
      checkOutput("t4_valid", 64'(aOutValid), 64'(0));
      checkOutput("t4_ctrl", 64'(aOutCtrl), 64'(0));
      checkOutput("t4_ready", 64'(aInReady), 64'(1));
      for (int n = 0; n < 3; n++) applyStimulus(0, 16'h0, 64'h0, 1, 0, 0);
      checkOutput("t4_no9", 64'(saw9), 64'(0));

      // Bubble counter saturation and clear priority.
      applyStimulus(0, 16'h0, 64'h0, 1, 0, 1);
      for (int n = 0; n < 20; n++) applyStimulus(0, 16'h0, 64'h0, 1, 0, 0);
      checkOutput("t5_sat", 64'(aBubble), 64'(15));
      applyStimulus(0, 16'h0, 64'h0, 1, 0, 1);
      checkOutput("t5_clr", 64'(aBubble), 64'(0));
      applyStimulus(0, 16'h0, 64'h0, 1, 0, 0);
      applyStimulus(0, 16'h0, 64'h0, 1, 0, 1);
      checkOutput("t5_clr_bubble", 64'(aBubble), 64'(0));

      // Flush data handling for both parameter settings.
      applyStimulus(1, 16'd5, 64'hDEAD, 0, 0, 0);
      checkOutput("t6_loadB", bOutData, 64'hDEAD);
      applyStimulus(0, 16'h0, 64'h0, 0, 1, 0);
      checkOutput("t6_keepA", aOutData, 64'hDEAD);
      checkOutput("t6_clearB", bOutData, 64'h0);
      checkOutput("t6_validB", 64'(bOutValid), 64'(0));
      checkOutput("t6_ctrlB", 64'(bOutCtrl), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
